sram_ctrl: RTL

Synchronous initiator for the asynchronous 4K×8 SRAM bus (active-low CSB/WRB, 12-bit ABUS, 8-bit bidirectional DBUS). It converts a single-outstanding valid/ready request port into correctly sequenced chip-select and write strobes, meeting the part's address-to-WRB-rise setup and 10 ns read access time. It sits between on-chip logic and the SRAM pins. The tri-state pad is split into out/oe/in here and merged in the pad ring.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default strobe timing for the asynchronous SRAM initiator.
package sram_ctrl_pkg;

    localparam int CNT_W         = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_WR_CYC    = 2;
    localparam int DEF_RD_CYC    = 2;
    localparam int DEF_TURN_CYC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_LOW,
        ST_WR_END,
        ST_RD_WAIT,
        ST_TURN
    } sram_ctrl_state_e;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-outstanding valid/ready initiator for the async 4Kx8 SRAM bus.
// All pin-facing strobes are registered; the DBUS tri-state is merged in the pad ring.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | req_ready=1, waiting for a request
// ST_SETUP   | address/data settle with csb/wrb high
// ST_WR_LOW  | csb and wrb low, write data driven
// ST_WR_END  | strobes high, SRAM latches; address/data held for hold time
// ST_RD_WAIT | csb low for access time, capture on last cycle
// ST_TURN    | csb high, SRAM releases DBUS before it may be driven again
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WR_CYC    = DEF_WR_CYC,
    parameter int RD_CYC    = DEF_RD_CYC,
    parameter int TURN_CYC  = DEF_TURN_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              csb,
    output logic              wrb,
    output logic [ADDR_W-1:0] abus,
    output logic [DATA_W-1:0] dbus_o,
    output logic              dbus_oe,
    input  logic [DATA_W-1:0] dbus_i
);

    sram_ctrl_state_e state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            csb       <= 1'b1;
            wrb       <= 1'b1;
            abus      <= '0;
            dbus_o    <= '0;
            dbus_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write <= req_write;
                        abus     <= req_addr;
                        if (req_write) begin
                            dbus_o <= req_wdata;
                        end
                        dbus_oe  <= req_write;
                        cnt      <= cyc_load(SETUP_CYC);
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        csb <= 1'b0;
                        if (is_write) begin
                            wrb   <= 1'b0;
                            cnt   <= cyc_load(WR_CYC);
                            state <= ST_WR_LOW;
                        end else begin
                            cnt   <= cyc_load(RD_CYC);
                            state <= ST_RD_WAIT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_LOW: begin
                    if (cnt == '0) begin
                        csb   <= 1'b1;
                        wrb   <= 1'b1;
                        state <= ST_WR_END;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_END: begin
                    dbus_oe <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= dbus_i;
                        rsp_valid <= 1'b1;
                        csb       <= 1'b1;
                        cnt       <= cyc_load(TURN_CYC);
                        state     <= ST_TURN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    csb     <= 1'b1;
                    wrb     <= 1'b1;
                    dbus_oe <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
